// File: rtl/dmem_responder.sv
// dmem_responder: target end of the CPU data-port load/store protocol.
// Accepts one word request and holds it for WAIT_CYCLES wait states. It then
// commits the store (byte-enabled) or captures the load data, and returns a
// response over a valid/ready handshake.
// Optional feature macro: DMEM_MISALIGN_CHK_EN adds rsp_err. A request with
// req_addr[1:0] != 0 then performs no memory access and answers with an error.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic        rsp_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic                    we_reg;
  logic                    mis_reg;
  logic [DEPTH_LOG2-1:0]   idx_reg;
  logic [31:0]             wdata_reg;
  logic [3:0]              be_reg;
  logic                    rsp_valid_reg;
  logic [31:0]             rsp_rdata_reg;
  logic                    rsp_err_reg;

  logic                    mis_next;
  logic                    commit;
  logic                    wr_en;
  logic [31:0]             rd_word;

  // Address bits outside the word index only matter for the misalignment check.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis_next = (req_addr[1:0] != 2'b00);
  assign rsp_err  = rsp_err_reg;
`else
  assign mis_next = 1'b0;
`endif

  // The counter is loaded with WAIT_CYCLES and the move to RESP happens on the
  // edge after it reaches zero. So WAIT always spans WAIT_CYCLES+1 edges,
  // including the WAIT_CYCLES = 0 case. This gives a uniform N+WAIT_CYCLES+1
  // response latency.
  assign commit = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign wr_en  = commit && we_reg && !mis_reg;

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

  // Storage is split into four byte lanes so each byte enable writes its own array.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [0:DEPTH-1];

    // Byte-lane write on the commit edge; contents survive reset.
    always_ff @(posedge clk) begin
      if (wr_en && be_reg[gi]) begin
        lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = lane_mem[idx_reg];
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      mis_reg       <= 1'b0;
      idx_reg       <= '0;
      wdata_reg     <= 32'd0;
      be_reg        <= 4'd0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            mis_reg   <= mis_next;
            idx_reg   <= req_addr[DEPTH_LOG2+1:2];
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            cnt_reg   <= 4'(WAIT_CYCLES);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= mis_reg;
            rsp_rdata_reg <= (we_reg || mis_reg) ? 32'd0 : rd_word;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder. It uses one instance with
// WAIT_CYCLES=2 and a second instance with WAIT_CYCLES=0 for the latency
// corner. Optional feature macro: DMEM_MISALIGN_CHK_EN.
module tb_dmem_responder;

  logic clk;
  logic rst;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        a_rsp_err, b_rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata)
`ifdef DMEM_MISALIGN_CHK_EN
    , .rsp_err(a_rsp_err)
`endif
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata)
`ifdef DMEM_MISALIGN_CHK_EN
    , .rsp_err(b_rsp_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One full transaction on instance A; reports data, error flag and latency
  // counted in edges after the accepting edge.
  task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata,
                       output logic err, output int lat);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = a_rsp_rdata;
`ifdef DMEM_MISALIGN_CHK_EN
    err = a_rsp_err;
`else
    err = 1'b0;
`endif
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    chk("a_rsp_valid_fall", {31'd0, a_rsp_valid}, 32'd0);
    chk("a_req_ready_back", {31'd0, a_req_ready}, 32'd1);
    chk("a_rdata_kept", a_rsp_rdata, rdata);
  endtask

  task automatic txn_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata,
                       output logic err, output int lat);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    lat = 0;
    while (!b_rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = b_rsp_rdata;
`ifdef DMEM_MISALIGN_CHK_EN
    err = b_rsp_err;
`else
    err = 1'b0;
`endif
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    chk("b_rsp_valid_fall", {31'd0, b_rsp_valid}, 32'd0);
    chk("b_req_ready_back", {31'd0, b_req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        mis;

`ifdef DMEM_MISALIGN_CHK_EN
    mis = 1'b1;
`else
    mis = 1'b0;
`endif

    //           we    addr          wdata         be    exp_rdata                      exp_err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,                         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF,                  1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0,                         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'h0,                         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'h11BB33DD,                  1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0040, 32'hCAFEF00D, 4'hF, 32'h0,                         1'b0};
    vecs[6]  = '{1'b0, 32'h0000_1040, 32'h0,        4'h0, 32'hCAFEF00D,                  1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0024, 32'h0BADF00D, 4'hF, 32'h0,                         1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0024, 32'h12345678, 4'h0, 32'h0,                         1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0024, 32'h0,        4'h0, 32'h0BADF00D,                  1'b0};
    vecs[10] = '{1'b1, 32'h0000_0080, 32'h00000000, 4'hF, 32'h0,                         1'b0};
    vecs[11] = '{1'b1, 32'h0000_0030, 32'h12345678, 4'hF, 32'h0,                         1'b0};
    vecs[12] = '{1'b0, 32'h0000_0033, 32'h0,        4'h0, mis ? 32'h0 : 32'h12345678,    mis};
    vecs[13] = '{1'b1, 32'h0000_0031, 32'hFFFFFFFF, 4'hF, 32'h0,                         mis};
    vecs[14] = '{1'b0, 32'h0000_0030, 32'h0,        4'h0, mis ? 32'h12345678 : 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_4010, 32'h0,        4'h0, 32'hDEADBEEF,                  1'b0};

    rst = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0;
    a_req_be = 4'd0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
    b_req_be = 4'd0; b_rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("reset_a_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("reset_a_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("reset_b_req_ready", {31'd0, b_req_ready}, 32'd1);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("reset_a_rsp_err", {31'd0, a_rsp_err}, 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven transactions on the WAIT_CYCLES=2 instance.
    for (int i = 0; i < 16; i++) begin
      txn_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      $display("txn %0d we=%0b addr=%08h wdata=%08h be=%h -> rdata=%08h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_latency", i), lat, 32'd3);
`ifdef DMEM_MISALIGN_CHK_EN
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
`endif
    end

    // Backpressure: response held while a competing request is presented.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 32'd3);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
    a_req_wdata = 32'h0; a_req_be = 4'hF;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, a_rsp_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_rdata", c), a_rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_hold%0d_req_ready", c), {31'd0, a_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
    $display("txn backpressure load 0x10 completed rdata=%08h", a_rsp_rdata);
    chk("bp_done_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("bp_done_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("bp_done_rdata_kept", a_rsp_rdata, 32'hDEADBEEF);
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    $display("txn load 0x10 after backpressure -> rdata=%08h lat=%0d", rd, lat);
    chk("bp_no_second_store", rd, 32'hDEADBEEF);

    // Zero-wait instance: response one edge after acceptance.
    txn_b(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
    $display("txn b store 0x30 -> rdata=%08h err=%0b lat=%0d", rd, er, lat);
    chk("b_store_latency", lat, 32'd1);
    chk("b_store_rdata", rd, 32'd0);
    txn_b(1'b0, 32'h33, 32'h0, 4'h0, rd, er, lat);
    $display("txn b load 0x33 -> rdata=%08h err=%0b lat=%0d", rd, er, lat);
    chk("b_mis_latency", lat, 32'd1);
    chk("b_mis_rdata", rd, mis ? 32'h0 : 32'h12345678);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("b_mis_err", {31'd0, er}, 32'd1);
`endif
    txn_b(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    $display("txn b load 0x30 -> rdata=%08h err=%0b lat=%0d", rd, er, lat);
    chk("b_load_latency", lat, 32'd1);
    chk("b_load_rdata", rd, 32'h12345678);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("b_load_err", {31'd0, er}, 32'd0);
`endif

    // Reset during WAIT drops the pending store.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h80;
    a_req_wdata = 32'h55AA55AA; a_req_be = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    chk("rstw_in_wait_req_ready", {31'd0, a_req_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    $display("txn store 0x80 aborted by reset in WAIT");
    chk("rstw_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rstw_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rstw_rsp_rdata", a_rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    txn_a(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
    $display("txn load 0x80 after reset -> rdata=%08h lat=%0d", rd, lat);
    chk("rstw_store_dropped", rd, 32'h0);
    chk("rstw_load_latency", lat, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
